pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Input-capture counterpart of the PWM/timer generator: measures period and high time of an external PWM waveform.
- Results are in prescaled ticks. Each completed measurement raises a 1-cycle valid/interrupt pulse.
- Sits beside the timer block on the same control/prescaler register set; feeds the bus register file and interrupt controller.

Parameters:
WIDTH, 32, width of prescalor, timeout, period and high_time
SYNC_STAGES, 2, metastability flops on pwm_in (min 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
control  input  2  mode: 00 off, 01 continuous capture, 10 single-shot, 11 reserved (treated as off)
prescalor  input  WIDTH  tick every prescalor+1 clk cycles (0 = every cycle)
timeout  input  WIDTH  ticks without an edge before abort (0 = disabled)
pwm_in  input  1  asynchronous PWM input
period  output  WIDTH  last captured rise-to-rise ticks
high_time  output  WIDTH  last captured rise-to-fall ticks
cap_valid  output  1  1-cycle pulse when period/high_time update
timeout_flag  output  1  sticky: no edge within timeout ticks
busy  output  1  state is not IDLE/DONE

Behaviour:
- Decided: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: all outputs and internal registers are 0; state is IDLE.
- Input path: SYNC_STAGES flops, then one previous-value register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - cap_valid asserts SYNC_STAGES+1 clk after the clk edge that first samples pwm_in high.
- Mode change: any cycle where control differs from the registered previous control:
  - clear the counters and period/high_time;
  - clear cap_valid and timeout_flag;
  - go to WAIT_RISE if the new mode is 01/10, else IDLE.
- Prescaler: cnt_pres counts 0..prescalor.
  - tick = (cnt_pres == prescalor).
  - cnt_pres clears on tick and on every rise.
- cnt:
  - set to 0 on rise;
  - otherwise increments on tick;
  - saturates at all-ones.
  - Captured value = cnt + tick (same-cycle tick included), saturating.
- States:
  - IDLE: nothing counts.
  - WAIT_RISE: on rise → MEASURE_HIGH; cnt = 0.
  - MEASURE_HIGH: on fall, high_latch = captured value → MEASURE_LOW.
  - MEASURE_LOW: on rise, period = captured value, high_time = high_latch, cap_valid = 1, timeout_flag cleared, cnt = 0. Next state is MEASURE_HIGH (mode 01) or DONE (mode 10).
  - DONE: holds results; leaving requires a control change.
- Timeout:
  - idle_cnt counts ticks since the last rise or fall, in WAIT_RISE/MEASURE_* only.
  - When timeout != 0 and idle_cnt reaches timeout: timeout_flag = 1, state → WAIT_RISE, period/high_time hold.
  - Covers 0% and 100% duty and a disconnected input.
- Simultaneous events:
  - Mode change beats all edges.
  - A timeout in the same cycle as an edge is ignored; the edge wins.
  - rise and fall cannot coincide.
- Reset mid-measurement: immediate abort to IDLE; no cap_valid.

Decomposition:
- Package pwm_pkg holds:
  - mode constants MODE_OFF/MODE_TIMER/MODE_PWM/MODE_CAPTURE/MODE_SINGLE;
  - the capture state enum (IDLE, WAIT_RISE, MEASURE_HIGH, MEASURE_LOW, DONE);
  - a WIDTH default shared with the generator.
- One sub-module, edge_sync: synchronizer plus edge detect, outputs sync/rise/fall.

Test Plan:
- Continuous, prescalor=0, pwm_in period 10 clk with high 3 clk, 5 periods → period=10, high_time=3, cap_valid once per period from the second rise; first pulse 3 clk after the second sampled rise.
- prescalor=1, pwm_in period 20 high 8 → period=10, high_time=4.
- Single-shot, same input as the first scenario → exactly one cap_valid, busy=0 afterwards, values held; toggle control 10→00→10 → a new capture occurs.
- timeout=50, prescalor=0, pwm_in held low → timeout_flag=1 at tick 50, period unchanged. Resume a 10/3 waveform → flag clears on the next cap_valid.
- Assert reset mid-MEASURE_LOW → all outputs 0 within the same cycle, no cap_valid; after release and mode 01, a normal capture follows.
- Change control 01→10 during MEASURE_HIGH → period/high_time cleared to 0, state restarts at WAIT_RISE.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode encodings, capture states and default width for the timer/PWM/capture blocks
package pwm_pkg;

   localparam int PWM_WIDTH = 32;

   // The generator and the capture unit decode the same 2-bit control field differently.
   localparam logic [1:0] MODE_OFF     = 2'b00;
   localparam logic [1:0] MODE_TIMER   = 2'b01;
   localparam logic [1:0] MODE_PWM     = 2'b10;
   localparam logic [1:0] MODE_CAPTURE = 2'b01;
   localparam logic [1:0] MODE_SINGLE  = 2'b10;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_RISE    = 3'd1,
      MEASURE_HIGH = 3'd2,
      MEASURE_LOW  = 3'd3,
      DONE         = 3'd4
   } cap_state_e;

endpackage

// File: rtl/pwm_capture_edge_sync.sv
// rtl/pwm_capture_edge_sync.sv - pwm_in synchronizer with registered rise/fall detection
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pwm_in,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // sync is the level aligned with rise/fall, i.e. the previous-value register.
   assign sync = prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= '0;
         prev  <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], pwm_in};
         prev  <= chain[SYNC_STAGES-1];
         rise  <= chain[SYNC_STAGES-1] & ~prev;
         fall  <= ~chain[SYNC_STAGES-1] & prev;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period and high time of an external PWM waveform in prescaled ticks
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int WIDTH       = PWM_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       control,
   input  logic [WIDTH-1:0] prescalor,
   input  logic [WIDTH-1:0] timeout,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             cap_valid,
   output logic             timeout_flag,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   cap_state_e       state;
   logic [1:0]       prev_control;
   logic [WIDTH-1:0] cnt_pres;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] idle_cnt;
   logic [WIDTH-1:0] high_latch;
   logic [WIDTH-1:0] captured;
   logic             sync;
   logic             rise;
   logic             fall;
   logic             tick;
   logic             active;
   logic             timeout_hit;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
      .clk    (clk),
      .reset  (reset),
      .pwm_in (pwm_in),
      .sync   (sync),
      .rise   (rise),
      .fall   (fall)
   );

   assign tick     = (cnt_pres == prescalor);
   assign active   = (state == WAIT_RISE) || (state == MEASURE_HIGH) || (state == MEASURE_LOW);
   assign busy     = active;
   // A tick landing on the capture edge is counted, so N ticks of waveform read as N.
   assign captured = (tick && cnt != '1) ? cnt + ONE : cnt;
   // An edge in the same cycle always beats the timeout.
   assign timeout_hit = (timeout != '0) && tick && !rise && !fall &&
                        (idle_cnt >= timeout - ONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         prev_control <= MODE_OFF;
         cnt_pres     <= '0;
         cnt          <= '0;
         idle_cnt     <= '0;
         high_latch   <= '0;
         period       <= '0;
         high_time    <= '0;
         cap_valid    <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         prev_control <= control;
         cap_valid    <= 1'b0;
         if (control != prev_control) begin
            cnt_pres     <= '0;
            cnt          <= '0;
            idle_cnt     <= '0;
            high_latch   <= '0;
            period       <= '0;
            high_time    <= '0;
            timeout_flag <= 1'b0;
            state        <= (control == MODE_CAPTURE || control == MODE_SINGLE) ? WAIT_RISE : IDLE;
         end else if (active) begin
            cnt_pres <= (tick || rise) ? '0 : cnt_pres + ONE;
            if (rise)
               cnt <= '0;
            else if (tick && cnt != '1)
               cnt <= cnt + ONE;
            if (rise || fall)
               idle_cnt <= '0;
            else if (tick && idle_cnt != '1)
               idle_cnt <= idle_cnt + ONE;

            if (timeout_hit) begin
               timeout_flag <= 1'b1;
               idle_cnt     <= '0;
               state        <= WAIT_RISE;
            end else begin
               case (state)
                  WAIT_RISE: if (rise) state <= MEASURE_HIGH;
                  MEASURE_HIGH: if (fall && !sync) begin
                     high_latch <= captured;
                     state      <= MEASURE_LOW;
                  end
                  MEASURE_LOW: if (rise) begin
                     period       <= captured;
                     high_time    <= high_latch;
                     cap_valid    <= 1'b1;
                     timeout_flag <= 1'b0;
                     state        <= (control == MODE_SINGLE) ? DONE : MEASURE_HIGH;
                  end
                  default: state <= state;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  control = 2'b00;
   logic [31:0] prescalor = '0;
   logic [31:0] timeout = '0;
   logic        pwm_in = 1'b0;
   logic [31:0] period;
   logic [31:0] high_time;
   logic        cap_valid;
   logic        timeout_flag;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int cyc;
   int cap_count;
   int first_cap;

   pwm_capture #(.WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .control      (control),
      .prescalor    (prescalor),
      .timeout      (timeout),
      .pwm_in       (pwm_in),
      .period       (period),
      .high_time    (high_time),
      .cap_valid    (cap_valid),
      .timeout_flag (timeout_flag),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_mode(input logic [1:0] m);
      @(negedge clk);
      control = m;
      repeat (2) @(negedge clk);
   endtask

   // Drives n periods of p clk with the first h clk high; samples cap_valid before each drive.
   task automatic run_wave(input int p, input int h, input int n);
      cyc = 0;
      cap_count = 0;
      first_cap = -1;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < p; i++) begin
            @(negedge clk);
            if (cap_valid) begin
               if (first_cap < 0) first_cap = cyc;
               cap_count++;
            end
            pwm_in = (i < h);
            cyc++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_period", period, 0);
      check("rst_high", high_time, 0);
      check("rst_valid", {31'd0, cap_valid}, 0);
      check("rst_flag", {31'd0, timeout_flag}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      reset = 1'b0;

      // continuous, prescalor 0, 10/3
      set_mode(2'b01);
      check("c_busy", {31'd0, busy}, 1);
      run_wave(10, 3, 5);
      check("c_count", cap_count, 4);
      check("c_first", first_cap, 14);
      check("c_period", period, 10);
      check("c_high", high_time, 3);

      // prescalor 1, 20/8
      set_mode(2'b00);
      prescalor = 32'd1;
      set_mode(2'b01);
      run_wave(20, 8, 3);
      check("p1_count", cap_count, 2);
      check("p1_period", period, 10);
      check("p1_high", high_time, 4);

      // single-shot
      prescalor = 32'd0;
      set_mode(2'b00);
      set_mode(2'b10);
      run_wave(10, 3, 5);
      check("s_count", cap_count, 1);
      check("s_busy", {31'd0, busy}, 0);
      check("s_period", period, 10);
      check("s_high", high_time, 3);
      set_mode(2'b00);
      check("s_off_period", period, 0);
      set_mode(2'b10);
      run_wave(10, 3, 3);
      check("s2_count", cap_count, 1);
      check("s2_period", period, 10);

      // timeout with input held low
      set_mode(2'b00);
      timeout = 32'd50;
      @(negedge clk);
      control = 2'b01;
      @(posedge clk);
      repeat (49) @(posedge clk);
      #1 check("to_early", {31'd0, timeout_flag}, 0);
      @(posedge clk);
      #1 check("to_flag", {31'd0, timeout_flag}, 1);
      check("to_period", period, 0);
      run_wave(10, 3, 3);
      check("to_cap", cap_count, 2);
      check("to_clear", {31'd0, timeout_flag}, 0);
      repeat (60) @(negedge clk);
      check("to_flag2", {31'd0, timeout_flag}, 1);
      check("to_hold_p", period, 10);
      check("to_hold_h", high_time, 3);

      // reset during MEASURE_LOW
      timeout = 32'd0;
      set_mode(2'b00);
      set_mode(2'b01);
      run_wave(10, 3, 2);
      check("r_busy", {31'd0, busy}, 1);
      check("r_pre_period", period, 10);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("r_period", period, 0);
      check("r_high", high_time, 0);
      check("r_valid", {31'd0, cap_valid}, 0);
      check("r_busy0", {31'd0, busy}, 0);
      cap_count = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 3) reset = 1'b0;
         if (cap_valid) cap_count++;
      end
      check("r_novalid", cap_count, 0);
      run_wave(10, 3, 3);
      check("r_count", cap_count, 2);
      check("r_period2", period, 10);
      check("r_high2", high_time, 3);

      // mode change during MEASURE_HIGH
      @(negedge clk);
      pwm_in = 1'b1;
      repeat (5) @(negedge clk);
      check("m_pre_period", period, 10);
      control = 2'b10;
      repeat (2) @(negedge clk);
      check("m_period", period, 0);
      check("m_high", high_time, 0);
      check("m_busy", {31'd0, busy}, 1);
      pwm_in = 1'b0;
      repeat (5) @(negedge clk);
      run_wave(10, 3, 2);
      check("m_count", cap_count, 1);
      check("m_period2", period, 10);
      check("m_high2", high_time, 3);
      check("m_busy2", {31'd0, busy}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
